nap_axi_burst_reader: RTL and testbench
=======================================

Name: nap_axi_burst_reader

Overview:
- AXI4 read-burst engine that sits directly upstream of the NAP master wrapper and drives the read-address and read-data channels of its responder interface.
- Turns one command (base address, beat count) into a sequence of INCR bursts:
  - no burst crosses a 4 KB boundary;
  - the number of outstanding bursts is capped;
  - each burst is at most MAX_BURST beats.
- Returned read data is forwarded as a valid/ready beat stream to downstream logic, e.g. a BRAM loader.
- Sticky response-error status is reported.

Parameters:
- ADDR_WIDTH, 42, AXI address width (NAP consumes bits [27:0]).
- DATA_WIDTH, 256, AXI data width; beat = DATA_WIDTH/8 bytes.
- ID_WIDTH, 8, arid/rid width.
- MAX_BURST, 16, maximum beats per burst (1..256).
- MAX_OUTSTANDING, 4, maximum bursts issued but not yet completed by rlast (1..16).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  single-cycle command strobe.
- i_base_addr  in  ADDR_WIDTH  start address; low log2(DATA_WIDTH/8) bits must be 0.
- i_num_beats  in  16  total beats to read.
- o_busy  out  1  command in progress.
- o_done  out  1  1-cycle pulse when the command completes.
- o_error  out  1  sticky: rresp!=0 or rlast mismatch seen since last start.
- o_cycles  out  32  performance count (see Optional Feature).
- o_arvalid  out  1  AR valid.
- i_arready  in  1  AR ready.
- o_araddr  out  ADDR_WIDTH  burst address.
- o_arlen  out  8  beats-1.
- o_arsize  out  3  log2(DATA_WIDTH/8), constant.
- o_arburst  out  2  2'b01 (INCR), constant.
- o_arid  out  ID_WIDTH  0, constant.
- o_arqos  out  4  0, constant.
- i_rvalid  in  1  R valid.
- o_rready  out  1  R ready.
- i_rdata  in  DATA_WIDTH  read data.
- i_rresp  in  2  read response.
- i_rlast  in  1  last beat of burst.
- i_rid  in  ID_WIDTH  ignored.
- o_data_valid  out  1  stream valid.
- i_data_ready  in  1  stream ready.
- o_data  out  DATA_WIDTH  stream data.

Behaviour:
- Clocking: single clock i_clk; reset is synchronous, active-high on i_reset.
- Reset values: o_busy=0, o_done=0, o_error=0, o_cycles=0, o_arvalid=0, o_araddr=0, o_arlen=0; internal counters cleared; state IDLE.
- State machine:
  - IDLE: on i_start, latch address and count, clear o_error and o_cycles.
    - If i_num_beats==0: go to DONE the next cycle without issuing AR.
    - Otherwise: go to ISSUE with o_busy=1 the cycle after i_start.
  - ISSUE: present one AR per burst.
    - len = min(remaining_req, MAX_BURST, (4096 - addr[11:0]) / beat_bytes).
    - o_arvalid is asserted only while outstanding < MAX_OUTSTANDING.
    - Once asserted, o_arvalid and all AR fields hold stable until i_arready.
    - On the handshake: addr += len*beat_bytes, remaining_req -= len, outstanding++.
    - Next burst may be presented the following cycle (back-to-back issue allowed).
    - When remaining_req==0, go to DRAIN.
  - DRAIN: wait until all beats are received and outstanding==0, then go to DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0, return to IDLE.
- i_start while o_busy=1 is ignored (no effect).
- R path is combinational pass-through:
  - o_data_valid = i_rvalid & o_busy;
  - o_rready = i_data_ready & o_busy;
  - o_data = i_rdata.
  - A beat is consumed when i_rvalid & o_rready.
- Per consumed beat: rx_count++.
  - On rlast: outstanding--.
  - Simultaneous AR handshake and rlast in the same cycle leave outstanding unchanged.
- o_error sets on any consumed beat with rresp!=0. The beat is still forwarded.
- o_error also sets when rlast appears at a beat index different from the issued burst length. Issued lengths are tracked in a FIFO of depth MAX_OUTSTANDING.
- Reset mid-operation: returns to IDLE immediately; in-flight NAP transactions are abandoned. The NAP must be reset in the same domain.
- All address arithmetic is modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro: NAP_AXI_BURST_READER_PERF_EN.
- Defined:
  - o_cycles counts cycles with o_busy=1 for the current command;
  - it saturates at 32'hFFFFFFFF;
  - it holds its value after o_done until the next i_start.
- Undefined: o_cycles is tied to 0 and no counter logic is present.

Test Plan:
- base=0x0, beats=64, arready=1, ready=1:
  - 4 ARs with arlen=15 at 0x0, 0x200, 0x400, 0x600;
  - 64 beats out, o_done once, o_error=0.
- base=0xF80 (beat_bytes=32), beats=20:
  - first AR arlen=3 at 0xF80;
  - second AR arlen=15 at 0x1000;
  - no burst crosses 4 KB.
- MAX_OUTSTANDING=4, beats=128, rvalid held low:
  - exactly 4 ARs issued, then o_arvalid=0;
  - after one burst completes, the 5th AR is issued.
- beats=16, rresp=2'b10 on beat 5, i_data_ready toggling 50%:
  - all 16 beats delivered in order;
  - o_error=1 sticky, cleared at next i_start.
- beats=0:
  - no AR;
  - o_done pulses 2 cycles after i_start.
- i_reset asserted mid-burst:
  - next cycle o_busy=0 and o_arvalid=0;
  - a fresh start completes normally;
  - with the PERF macro defined, o_cycles = cycles start→done.

Source files
------------

// File: rtl/nap_axi_burst_reader_if.sv
// nap_axi_burst_reader_if: AXI4 read-address and read-data channels between burst reader and NAP.
interface nap_axi_burst_reader_if #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [ID_WIDTH-1:0]   arid;
  logic [3:0]            arqos;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;
  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, arqos, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );
  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, arqos, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/nap_axi_burst_reader.sv
// nap_axi_burst_reader: splits a read command into 4KB-safe INCR bursts and streams the returned beats.
// Define NAP_AXI_BURST_READER_PERF_EN to enable the o_cycles busy-cycle counter.
module nap_axi_burst_reader #(
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [15:0]           i_num_beats,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [31:0]           o_cycles,
  nap_axi_burst_reader_if.master axi,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam int BB = DATA_WIDTH / 8;
  localparam int SZ = $clog2(BB);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           remaining;
  logic [4:0]            outstanding, out_next;
  logic [7:0]            beat_idx;
  logic [7:0]            len_q [2**PW];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [16:0]           to_bound, len_a, len;
  logic                  ar_hs, r_hs, last_hs, issue_ok, r_err;
  assign axi.arsize    = 3'(SZ);
  assign axi.arburst   = 2'b01;
  assign axi.arid      = '0;
  assign axi.arqos     = '0;
  assign axi.rready    = i_data_ready & o_busy;
  assign o_data_valid  = axi.rvalid & o_busy;
  assign o_data        = axi.rdata;
  assign ar_hs    = axi.arvalid & axi.arready;
  assign r_hs     = axi.rvalid & axi.rready;
  assign last_hs  = r_hs & axi.rlast;
  assign out_next = outstanding + {4'd0, ar_hs} - {4'd0, last_hs};
  // beats left before the next 4KB page: (4096 - addr[11:0]) / BB
  assign to_bound = 17'((13'({1'b0, ~addr[11:0]}) + 13'd1) >> SZ);
  assign len_a    = {1'b0, remaining} < 17'(MAX_BURST) ? {1'b0, remaining} : 17'(MAX_BURST);
  assign len      = len_a < to_bound ? len_a : to_bound;
  // a new AR may be presented only when the channel is free next cycle and the cap allows it
  assign issue_ok = state == ISSUE && remaining != 0 && (!axi.arvalid || axi.arready)
                    && out_next < 5'(MAX_OUTSTANDING);
  assign r_err    = r_hs & ((axi.rresp != 2'b00) | (outstanding == 0)
                    | (axi.rlast != (beat_idx == len_q[rd_ptr])));
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      beat_idx    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
    end else begin
      o_done      <= 1'b0;
      outstanding <= out_next;
      if (ar_hs) begin
        len_q[wr_ptr] <= axi.arlen;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (r_hs) beat_idx <= axi.rlast ? 8'd0 : beat_idx + 8'd1;
      if (last_hs) rd_ptr <= rd_ptr + 1'b1;
      if (r_err) o_error <= 1'b1;
      if (issue_ok) begin
        axi.arvalid <= 1'b1;
        axi.araddr  <= addr;
        axi.arlen   <= 8'(len - 17'd1);
        addr        <= addr + (ADDR_WIDTH'(len) << SZ);
        remaining   <= remaining - 16'(len);
      end else if (ar_hs) begin
        axi.arvalid <= 1'b0;
      end
      case (state)
        IDLE: if (i_start) begin
          addr      <= i_base_addr;
          remaining <= i_num_beats;
          o_error   <= 1'b0;
          o_busy    <= i_num_beats != 16'd0;
          state     <= i_num_beats == 16'd0 ? DONE : ISSUE;
        end
        ISSUE: if (remaining == 0 && (!axi.arvalid || axi.arready)) state <= DRAIN;
        DRAIN: if (out_next == 0) begin
          o_busy <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          o_done <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end
`ifdef NAP_AXI_BURST_READER_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) o_cycles <= '0;
    else if (state == IDLE && i_start) o_cycles <= '0;
    else if (o_busy && o_cycles != 32'hFFFF_FFFF) o_cycles <= o_cycles + 32'd1;
  end
`else
  assign o_cycles = '0;
`endif
endmodule

// File: tb/tb_nap_axi_burst_reader.sv
// tb_nap_axi_burst_reader: directed and randomized checks of nap_axi_burst_reader against a burst-split model.
module tb_nap_axi_burst_reader;
  typedef struct { logic [41:0] a; int len; } burst_t;
  logic         clk = 1'b0;
  logic         rst, start, busy, done, err, data_valid, data_ready;
  logic [41:0]  base;
  logic [15:0]  nb;
  logic [31:0]  cycles, seed;
  logic [255:0] data;
  burst_t       exp_q[$];
  int           resp_q[$];
  int tests = 0, fails = 0;
  int r_beat, rk, fwd, ar_cnt, done_cnt, busy_cnt, outst, err_beat, cur_n;
  int ar_rate, rv_rate, dr_rate, cyc, done_cyc, first_last_cyc, fifth_ar_cyc;
  logic         r_pend, ar_hold;
  logic [41:0]  h_addr;
  logic [7:0]   h_len;

  nap_axi_burst_reader_if #(.ADDR_WIDTH(42), .DATA_WIDTH(256), .ID_WIDTH(8)) axi();

  nap_axi_burst_reader #(
    .ADDR_WIDTH(42), .DATA_WIDTH(256), .ID_WIDTH(8), .MAX_BURST(16), .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_base_addr(base), .i_num_beats(nb),
    .o_busy(busy), .o_done(done), .o_error(err), .o_cycles(cycles), .axi(axi.master),
    .o_data_valid(data_valid), .i_data_ready(data_ready), .o_data(data)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] f(int k);
    logic [31:0] w;
    w = (32'(k) * 32'h9E37_79B1) ^ seed;
    return {8{w}};
  endfunction

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    burst_t b;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    axi.arready = $urandom_range(99) < ar_rate;
    if (!r_pend) begin
      if (resp_q.size() > 0 && $urandom_range(99) < rv_rate) begin
        axi.rvalid = 1'b1;
        axi.rdata  = f(rk);
        axi.rlast  = r_beat == resp_q[0] - 1;
        axi.rresp  = rk == err_beat ? 2'b10 : 2'b00;
        axi.rid    = 8'($urandom);
        r_pend     = 1'b1;
      end else begin
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
      end
    end
    data_ready = $urandom_range(99) < dr_rate;
    #1;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (ar_hold) begin
      check("ar_hold_valid", axi.arvalid, 1'b1);
      check("ar_hold_addr", axi.araddr, h_addr);
      check("ar_hold_len", axi.arlen, h_len);
    end
    ar_hold = axi.arvalid && !axi.arready;
    h_addr  = axi.araddr;
    h_len   = axi.arlen;
    if (axi.arvalid && axi.arready) begin
      ar_cnt++;
      if (exp_q.size() == 0) check("ar_extra", ar_cnt, 0);
      else begin
        b = exp_q.pop_front();
        check("araddr", axi.araddr, b.a);
        check("arlen", axi.arlen, 8'(b.len - 1));
      end
      resp_q.push_back(int'(axi.arlen) + 1);
      outst++;
      check("outstanding_cap", outst <= 4, 1'b1);
      if (ar_cnt == 5) fifth_ar_cyc = cyc;
    end
    if (axi.rvalid && axi.rready) begin
      check("stream_valid", data_valid, 1'b1);
      check("data", data, f(fwd));
      fwd++;
      rk++;
      r_pend = 1'b0;
      if (axi.rlast) begin
        r_beat = 0;
        void'(resp_q.pop_front());
        outst--;
        if (first_last_cyc < 0) first_last_cyc = cyc;
      end else r_beat++;
    end
  endtask

  task automatic start_cmd(logic [41:0] b, int n, int eb);
    logic [41:0] a;
    int rem, l;
    a = b;
    rem = n;
    exp_q.delete();
    while (rem > 0) begin
      l = rem < 16 ? rem : 16;
      if ((4096 - int'(a[11:0])) / 32 < l) l = (4096 - int'(a[11:0])) / 32;
      exp_q.push_back('{a, l});
      a = a + 42'(l * 32);
      rem -= l;
    end
    {rk, fwd, ar_cnt, done_cnt, busy_cnt, cyc, r_beat} = '0;
    {done_cyc, first_last_cyc, fifth_ar_cyc} = {-1, -1, -1};
    ar_hold  = 1'b0;
    err_beat = eb;
    cur_n    = n;
    @(negedge clk);
    start = 1'b1;
    base  = b;
    nb    = 16'(n);
    cycle();
    check("busy_after_start", busy, n != 0);
    check("error_cleared", err, 1'b0);
  endtask

  task automatic run_done(int budget);
    while (done_cnt == 0 && cyc < budget) cycle();
    check("done_seen", done_cnt, 1);
    repeat (3) cycle();
    check("done_once", done_cnt, 1);
    check("beats_forwarded", fwd, cur_n);
    check("ars_all_issued", exp_q.size(), 0);
    check("error_state", err, err_beat >= 0 && err_beat < cur_n);
    check("busy_idle", busy, 1'b0);
`ifdef NAP_AXI_BURST_READER_PERF_EN
    check("cycles", cycles, busy_cnt);
`else
    check("cycles_off", cycles, 0);
`endif
  endtask

  initial begin
    seed = $urandom;
    rst = 1'b1; start = 1'b0; base = '0; nb = '0; data_ready = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    axi.rlast = 1'b0; axi.rid = '0;
    r_pend = 1'b0; ar_hold = 1'b0; outst = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", err, 1'b0);
    check("rst_cycles", cycles, 0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_araddr", axi.araddr, 0);
    check("rst_arlen", axi.arlen, 0);
    check("arsize", axi.arsize, 3'd5);
    check("arburst", axi.arburst, 2'b01);
    check("arid", axi.arid, 0);
    check("arqos", axi.arqos, 0);
    rst = 1'b0;
    // aligned 64-beat read, all ready
    {ar_rate, rv_rate, dr_rate} = {100, 100, 100};
    start_cmd(42'h0, 64, -1);
    run_done(2000);
    // start just below a 4KB page boundary
    start_cmd(42'hF80, 20, -1);
    run_done(2000);
    // outstanding cap with read data withheld
    rv_rate = 0;
    start_cmd(42'h0, 128, -1);
    repeat (30) cycle();
    check("cap_ars", ar_cnt, 4);
    check("cap_arvalid", axi.arvalid, 1'b0);
    rv_rate = 100;
    run_done(3000);
    check("fifth_after_first_done", fifth_ar_cyc > first_last_cyc && fifth_ar_cyc - first_last_cyc <= 3, 1'b1);
    // error response on beat 5 with throttled downstream
    {ar_rate, rv_rate, dr_rate} = {100, 100, 50};
    start_cmd(42'h3000, 16, 5);
    run_done(2000);
    check("error_sticky", err, 1'b1);
    // zero-beat command: no AR, done two cycles after start
    start_cmd(42'h40, 0, -1);
    run_done(100);
    check("zero_done_timing", done_cyc, 2);
    check("zero_no_ar", ar_cnt, 0);
    // reset in the middle of a command
    {ar_rate, rv_rate, dr_rate} = {100, 60, 100};
    start_cmd(42'h2000, 128, -1);
    repeat (20) cycle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    axi.rvalid = 1'b0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_arvalid", axi.arvalid, 1'b0);
    check("reset_error", err, 1'b0);
    resp_q.delete();
    r_pend = 1'b0;
    outst  = 0;
    start_cmd(42'h1FE0, 40, -1);
    run_done(3000);
    // randomized commands near page boundaries
    for (int i = 0; i < 6; i++) begin
      int n;
      logic [41:0] b;
      n = int'($urandom_range(1, 100));
      b = 42'(32'h1000 * $urandom_range(0, 3) + 32 * $urandom_range(96, 127));
      ar_rate = int'($urandom_range(30, 100));
      rv_rate = int'($urandom_range(30, 100));
      dr_rate = int'($urandom_range(30, 100));
      start_cmd(b, n, $urandom_range(0, 1) == 1 ? int'($urandom_range(0, 99)) : -1);
      run_done(5000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
